// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: XNOR tap table, checker FSM states, counter widths
// and a popcount helper for the optional bit-error counter.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } chk_state_t;

    localparam int unsigned ERR_CNT_W     = 16;
    localparam int unsigned WORD_CNT_W    = 32;
    localparam int unsigned BIT_ERR_CNT_W = 32;

    // Zero-based tap positions; the generator uses the same table, so edits must stay in sync.
    function automatic logic [31:0] tap_mask(input int unsigned n);
        case (n)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR successor: shift left, XNOR feedback from the shared tap table.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned NUM_BITS = 32
) (
    input  logic [NUM_BITS-1:0] state,
    output logic [NUM_BITS-1:0] next_state
);

    localparam logic [31:0] TAP_MASK = tap_mask(NUM_BITS);

    logic feedback;

    assign feedback   = ~^(state & TAP_MASK[NUM_BITS-1:0]);
    assign next_state = {state[NUM_BITS-2:0], feedback};

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker for the LFSR generator stream.
// Optional LFSR_CHK_BITERR_EN adds a saturating per-bit error counter output.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned NUM_BITS   = 32,
    parameter int unsigned SYNC_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_DV,
    input  logic [NUM_BITS-1:0]   i_Data,
    output logic                  o_Locked,
    output logic                  o_Err,
    output logic                  o_Wrap,
    output logic [ERR_CNT_W-1:0]  o_Err_Count,
    output logic [WORD_CNT_W-1:0] o_Word_Count
`ifdef LFSR_CHK_BITERR_EN
    ,
    output logic [BIT_ERR_CNT_W-1:0] o_Bit_Err_Count
`endif
);

    localparam int unsigned MATCH_W = $clog2(SYNC_COUNT + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_COUNT + 1);

    chk_state_t             r_state, state_d;
    logic [NUM_BITS-1:0]    r_expect, expect_d;
    logic [NUM_BITS-1:0]    r_first, first_d;
    logic [MATCH_W-1:0]     r_match, match_d, match_inc;
    logic [MISS_W-1:0]      r_miss, miss_d, miss_inc;
    logic                   r_err, err_d;
    logic                   r_wrap, wrap_d;
    logic [ERR_CNT_W-1:0]   r_err_cnt, err_cnt_d;
    logic [WORD_CNT_W-1:0]  r_word_cnt, word_cnt_d;
    logic [NUM_BITS-1:0]    expect_next, data_next;
    logic                   hit;

    lfsr_next #(.NUM_BITS(NUM_BITS)) u_next_expect (
        .state      (r_expect),
        .next_state (expect_next)
    );

    lfsr_next #(.NUM_BITS(NUM_BITS)) u_next_data (
        .state      (i_Data),
        .next_state (data_next)
    );

    assign hit       = (i_Data == r_expect);
    assign match_inc = r_match + 1'b1;
    assign miss_inc  = r_miss + 1'b1;

`ifdef LFSR_CHK_BITERR_EN
    logic [BIT_ERR_CNT_W-1:0] r_bit_err, bit_err_d;
    logic [BIT_ERR_CNT_W:0]   bit_err_sum;

    assign bit_err_sum = {1'b0, r_bit_err}
                       + (BIT_ERR_CNT_W + 1)'(popcount32(32'(i_Data ^ r_expect)));
`endif

    always_comb begin
        state_d    = r_state;
        expect_d   = r_expect;
        first_d    = r_first;
        match_d    = r_match;
        miss_d     = r_miss;
        err_d      = 1'b0;
        wrap_d     = 1'b0;
        err_cnt_d  = r_err_cnt;
        word_cnt_d = r_word_cnt;
`ifdef LFSR_CHK_BITERR_EN
        bit_err_d  = r_bit_err;
`endif
        if (i_DV) begin
            unique case (r_state)
                IDLE: begin
                    if (i_Data != '1) begin
                        expect_d = data_next;
                        first_d  = i_Data;
                        match_d  = '0;
                        state_d  = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (hit) begin
                        expect_d = expect_next;
                        match_d  = match_inc;
                        if (match_inc == MATCH_W'(SYNC_COUNT)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        expect_d = data_next;
                        first_d  = i_Data;
                        match_d  = '0;
                    end
                end
                LOCKED: begin
                    word_cnt_d = r_word_cnt + 1'b1;
                    expect_d   = expect_next;
                    if (hit) begin
                        miss_d = '0;
                        wrap_d = (i_Data == r_first);
                    end else begin
                        err_d = 1'b1;
                        if (r_err_cnt != '1) begin
                            err_cnt_d = r_err_cnt + 1'b1;
                        end
`ifdef LFSR_CHK_BITERR_EN
                        bit_err_d = bit_err_sum[BIT_ERR_CNT_W] ? '1 : bit_err_sum[BIT_ERR_CNT_W-1:0];
`endif
                        // Final miss overrides the free-running advance with a reload.
                        if (miss_inc == MISS_W'(LOSS_COUNT)) begin
                            state_d  = ACQUIRE;
                            expect_d = data_next;
                            first_d  = i_Data;
                            match_d  = '0;
                            miss_d   = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state    <= IDLE;
            r_expect   <= '0;
            r_first    <= '0;
            r_match    <= '0;
            r_miss     <= '0;
            r_err      <= 1'b0;
            r_wrap     <= 1'b0;
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
`ifdef LFSR_CHK_BITERR_EN
            r_bit_err  <= '0;
`endif
        end else begin
            r_state    <= state_d;
            r_expect   <= expect_d;
            r_first    <= first_d;
            r_match    <= match_d;
            r_miss     <= miss_d;
            r_err      <= err_d;
            r_wrap     <= wrap_d;
            r_err_cnt  <= err_cnt_d;
            r_word_cnt <= word_cnt_d;
`ifdef LFSR_CHK_BITERR_EN
            r_bit_err  <= bit_err_d;
`endif
        end
    end

    assign o_Locked     = (r_state == LOCKED);
    assign o_Err        = r_err;
    assign o_Wrap       = r_wrap;
    assign o_Err_Count  = r_err_cnt;
    assign o_Word_Count = r_word_cnt;
`ifdef LFSR_CHK_BITERR_EN
    assign o_Bit_Err_Count = r_bit_err;
`endif

endmodule
